// File: rtl/alu_pkg.sv
// alu_pkg: shared divider state encoding and constants
package alu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_e;
  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;
endpackage

// File: rtl/divider_seq_if.sv
// divider_seq_if: start/done handshake and operand/result bus of the sequential divider
interface divider_seq_if import alu_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
  logic start;
  logic signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic div_by_zero;
  modport master(output start, signed_op, a, b, input busy, done, quotient, remainder, div_by_zero);
  modport slave(input start, signed_op, a, b, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/divider_seq_div_step.sv
// div_step: one combinational restoring-division iteration
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] r,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);
  logic [WIDTH:0] r_sh, diff;
  assign r_sh = {r, bit_in};
  assign diff = r_sh - {1'b0, d};
  // r < d keeps a non-negative diff below 2^WIDTH, so the top bit is a clean borrow
  assign q_bit = ~diff[WIDTH];
  assign r_next = q_bit ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
endmodule

// File: rtl/divider_seq.sv
// divider_seq: multi-cycle restoring divider for DIV/DIVU (LO=quotient, HI=remainder).
// Define DIV_SIGNED_EN to honour signed_op; otherwise every operation is unsigned.
module divider_seq import alu_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
  input logic clk,
  input logic rst,
  divider_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  div_state_e state, state_d;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] dq, r, d, r_step, q_out, r_out, a_mag, b_mag;
  logic q_bit, dz, accept, b_zero;
`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r, a_neg, b_neg;
  assign a_neg = bus.signed_op & bus.a[WIDTH-1];
  assign b_neg = bus.signed_op & bus.b[WIDTH-1];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;
`else
  assign a_mag = bus.a;
  assign b_mag = bus.b;
`endif
  assign accept = state == IDLE && bus.start;
  assign b_zero = bus.b == '0;
  div_step #(.WIDTH(WIDTH)) u_step (
    .r(r), .bit_in(dq[WIDTH-1]), .d(d), .r_next(r_step), .q_bit(q_bit)
  );
  always_comb begin
    state_d = state == IDLE ? (bus.start ? (b_zero ? DONE : RUN) : IDLE) :
              state == RUN  ? (count == '0 ? FIX : RUN) :
              state == FIX  ? DONE : IDLE;
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q_out <= '0;
      r_out <= '0;
      dz <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        dz <= b_zero;
        d <= b_mag;
        dq <= a_mag;
        r <= '0;
        count <= CW'(WIDTH-1);
`ifdef DIV_SIGNED_EN
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
`endif
        if (b_zero) begin
          q_out <= '1;
          r_out <= bus.a;
        end
      end
      // dq holds the remaining dividend bits on the left and the quotient bits on the right
      if (state == RUN) begin
        r <= r_step;
        dq <= {dq[WIDTH-2:0], q_bit};
        count <= count - 1'b1;
      end
      if (state == FIX) begin
`ifdef DIV_SIGNED_EN
        q_out <= neg_q ? -dq : dq;
        r_out <= neg_r ? -r : r;
`else
        q_out <= dq;
        r_out <= r;
`endif
      end
    end
  end
  assign bus.quotient = q_out;
  assign bus.remainder = r_out;
  assign bus.div_by_zero = dz;
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: randomized self-checking bench for divider_seq against an arithmetic model
module tb_divider_seq;
  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] last_q = '0, last_r = '0;
  divider_seq_if #(.WIDTH(W)) bus ();
  divider_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb;
    if (s & SGN_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    z = b == '0;
    if (z) begin
      q = '1;
      r = a;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  task automatic do_op(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
    logic [W-1:0] eq, er;
    logic ez;
    int n, bad;
    ref_div(s, a, b, eq, er, ez);
    bus.signed_op = s;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 1;
    bad = 0;
    while (!bus.done && n < 200) begin
      if (!bus.busy || bus.quotient !== last_q || bus.remainder !== last_r) bad++;
      bus.start = n == poke;
      if (n == poke) begin
        bus.a = 9;
        bus.b = 3;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n++;
    end
    chk({tag, "_lat"}, W'(n), W'(ez ? 1 : W + 2));
    chk({tag, "_stable"}, W'(bad), '0);
    chk({tag, "_busy"}, W'(bus.busy), W'(1));
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
    chk({tag, "_dz"}, W'(bus.div_by_zero), W'(ez));
    last_q = eq;
    last_r = er;
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, W'(bus.done), '0);
    chk({tag, "_idle"}, W'(bus.busy), '0);
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0;
    bus.signed_op = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_q", bus.quotient, '0);
    chk("rst_r", bus.remainder, '0);
    chk("rst_dz", W'(bus.div_by_zero), '0);
    rst = 1'b0;
    do_op("udiv", 1'b0, 100, 7, 0);
    do_op("sdiv_neg_a", 1'b1, 32'hFFFF_FFF9, 2, 0);
    do_op("sdiv_neg_b", 1'b1, 7, 32'hFFFF_FFFE, 0);
    do_op("divzero", 1'b0, 32'h1234_5678, 0, 0);
    do_op("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("udiv_sgnpat", 1'b0, 32'hFFFF_FFFA, 2, 0);
    do_op("sflag_neg", 1'b1, 32'hFFFF_FFFA, 2, 0);
    do_op("ignored", 1'b0, 100, 7, 10);
    do_op("b2b", 1'b0, 9, 3, 0);
    do_op("big_div", 1'b0, 32'h0000_0005, 32'hFFFF_FFFF, 0);
    bus.signed_op = 1'b0;
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'h0000_0013;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", W'(bus.busy), '0);
    chk("abort_done", W'(bus.done), '0);
    chk("abort_q", bus.quotient, '0);
    chk("abort_r", bus.remainder, '0);
    chk("abort_dz", W'(bus.div_by_zero), '0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    chk("abort_nodone", W'(seen), '0);
    last_q = '0;
    last_r = '0;
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(3))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 20));
        2: rb = -W'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      do_op($sformatf("rnd%0d", i), 1'($urandom_range(1)), ra, rb, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
